// File: rtl/spi_sram_bridge.sv
// spi_sram_bridge
//   Turns single-sample read/write requests from the memory controller into
//   SPI mode-0 (MSB first) transactions on a 23LC1024-class serial SRAM and
//   returns read data. One request in flight; req_ready doubles as the
//   controller's off_chip_mem_ready.
//   Frame: command byte (0x02 write / 0x03 read), ADDR_BYTES address bytes,
//   then DATA_W data bits (write data on MOSI, MOSI=0 while reading).
//   Sequence per frame: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE, where
//   SETUP/HOLD/GAP and every SCLK half-period last CLK_DIV clk cycles.
//   Build macro SPI_SRAM_INIT_EN: after reset release, send the 16-bit WRMR
//   frame 0x01 0x40 (sequential mode) before accepting any request.
module spi_sram_bridge #(
   parameter int DATA_W     = 16,
   parameter int ADDR_BYTES = 3,
   parameter int CLK_DIV    = 2
) (
   input  logic                    clk,
   input  logic                    rstb,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [8*ADDR_BYTES-1:0] req_addr,
   input  logic [DATA_W-1:0]       req_wdata,
   output logic                    rsp_valid,
   output logic [DATA_W-1:0]       rsp_rdata,
   output logic                    spi_sclk,
   output logic                    spi_cs_n,
   output logic                    spi_mosi,
   input  logic                    spi_miso
);

   localparam int N    = 8 + 8*ADDR_BYTES + DATA_W;
   localparam int HP_W = $clog2(CLK_DIV + 1);
   localparam int BC_W = $clog2(N + 1);

   localparam logic [HP_W-1:0] HP_LAST  = HP_W'(CLK_DIV - 1);
   localparam logic [BC_W-1:0] BC_FULL  = BC_W'(N);
   localparam logic [BC_W-1:0] BC_INIT  = BC_W'(16);
   localparam logic [7:0]      CMD_WR   = 8'h02;
   localparam logic [7:0]      CMD_RD   = 8'h03;

   // WRMR command + sequential-mode byte, left-aligned so it leaves MOSI first
   localparam logic [N-1:0]    INIT_FRAME = {8'h01, 8'h40, {(N-16){1'b0}}};

`ifdef SPI_SRAM_INIT_EN
   localparam logic INIT_EN = 1'b1;
`else
   localparam logic INIT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_GAP
   } state_t;

   // control registers
   state_t            state_q, state_d;
   logic [HP_W-1:0]   hp_q, hp_d;
   logic [BC_W-1:0]   bcnt_q, bcnt_d;
   logic              init_pend_q, init_pend_d;
   logic              sclk_q, sclk_d;
   logic              cs_n_q, cs_n_d;
   logic              mosi_q, mosi_d;
   logic              ready_q, ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   // datapath registers (reloaded at every frame start)
   logic [N-1:0]      sr_q, sr_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic              we_q, we_d;
   logic              init_frame_q, init_frame_d;

   // request frame assembly
   logic [DATA_W-1:0] tx_data;
   logic [N-1:0]      req_frame;

   // next-state, SPI pin and response logic
   always_comb begin
      state_d      = state_q;
      hp_d         = hp_q;
      bcnt_d       = bcnt_q;
      init_pend_d  = init_pend_q;
      sclk_d       = sclk_q;
      cs_n_d       = cs_n_q;
      mosi_d       = mosi_q;
      rsp_valid_d  = 1'b0;
      rdata_d      = rdata_q;
      sr_d         = sr_q;
      rx_d         = rx_q;
      we_d         = we_q;
      init_frame_d = init_frame_q;

      tx_data   = req_we ? req_wdata : '0;
      req_frame = {(req_we ? CMD_WR : CMD_RD), req_addr, tx_data};

      case (state_q)
         S_IDLE: begin
            if (init_pend_q) begin
               // mode-register frame has priority over any request
               state_d      = S_SETUP;
               hp_d         = HP_LAST;
               bcnt_d       = BC_INIT;
               sr_d         = INIT_FRAME;
               mosi_d       = INIT_FRAME[N-1];
               init_frame_d = 1'b1;
               init_pend_d  = 1'b0;
               cs_n_d       = 1'b0;
               sclk_d       = 1'b0;
            end else if (req_valid && ready_q) begin
               state_d      = S_SETUP;
               hp_d         = HP_LAST;
               bcnt_d       = BC_FULL;
               sr_d         = req_frame;
               mosi_d       = req_frame[N-1];
               we_d         = req_we;
               init_frame_d = 1'b0;
               cs_n_d       = 1'b0;
               sclk_d       = 1'b0;
            end
         end

         S_SETUP: begin
            if (hp_q == '0) begin
               // first rising edge: SRAM and bridge both sample here
               state_d = S_SHIFT;
               hp_d    = HP_LAST;
               sclk_d  = 1'b1;
               rx_d    = {rx_q[DATA_W-2:0], spi_miso};
            end else begin
               hp_d = hp_q - HP_W'(1);
            end
         end

         S_SHIFT: begin
            if (hp_q == '0) begin
               hp_d = HP_LAST;
               if (sclk_q) begin
                  // falling edge: advance MOSI, one more bit done
                  sclk_d = 1'b0;
                  sr_d   = {sr_q[N-2:0], 1'b0};
                  mosi_d = sr_q[N-2];
                  bcnt_d = (bcnt_q == '0) ? '0 : bcnt_q - BC_W'(1);
               end else if (bcnt_q == '0) begin
                  // last low half-period finished, SCLK parked low
                  state_d = S_HOLD;
               end else begin
                  sclk_d = 1'b1;
                  rx_d   = {rx_q[DATA_W-2:0], spi_miso};
               end
            end else begin
               hp_d = hp_q - HP_W'(1);
            end
         end

         S_HOLD: begin
            if (hp_q == '0) begin
               state_d     = S_GAP;
               hp_d        = HP_LAST;
               cs_n_d      = 1'b1;
               rsp_valid_d = !init_frame_q;
               if (!init_frame_q && !we_q) begin
                  rdata_d = rx_q;
               end
            end else begin
               hp_d = hp_q - HP_W'(1);
            end
         end

         S_GAP: begin
            if (hp_q == '0) begin
               state_d = S_IDLE;
            end else begin
               hp_d = hp_q - HP_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
         end
      endcase

      ready_d = (state_d == S_IDLE) && !init_pend_d;
   end

   // control state and registered outputs, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q     <= S_IDLE;
         hp_q        <= '0;
         bcnt_q      <= '0;
         init_pend_q <= INIT_EN;
         sclk_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         mosi_q      <= 1'b0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         hp_q        <= hp_d;
         bcnt_q      <= bcnt_d;
         init_pend_q <= init_pend_d;
         sclk_q      <= sclk_d;
         cs_n_q      <= cs_n_d;
         mosi_q      <= mosi_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
      end
   end

   // shift registers and captured request fields, overwritten at frame start
   always_ff @(posedge clk) begin
      sr_q         <= sr_d;
      rx_q         <= rx_d;
      we_q         <= we_d;
      init_frame_q <= init_frame_d;
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign spi_sclk  = sclk_q;
   assign spi_cs_n  = cs_n_q;
   assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_sram_bridge.sv
// tb_spi_sram_bridge
//   Directed bench for spi_sram_bridge at default parameters with a small
//   behavioural 23LC1024 model on the SPI pins. Stimulus pushes expected
//   responses (frame bits, read data, latency) into a queue; a monitor pops
//   and compares on every rsp_valid. Build with SPI_SRAM_INIT_EN defined to
//   exercise the mode-register frame after reset.
`timescale 1ns/1ps
module tb_spi_sram_bridge;

   logic        clk = 1'b0;
   logic        rstb;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [23:0] req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        spi_sclk;
   logic        spi_cs_n;
   logic        spi_mosi;
   logic        miso = 1'b0;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      int          t_acc;
      logic [63:0] frame;
      logic [15:0] rdata;
   } exp_t;
   exp_t exp_q[$];

   spi_sram_bridge dut (
      .clk       (clk),
      .rstb      (rstb),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .spi_sclk  (spi_sclk),
      .spi_cs_n  (spi_cs_n),
      .spi_mosi  (spi_mosi),
      .spi_miso  (miso)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- serial SRAM model ----------------
   logic [7:0]  mem [0:1023] = '{default: 8'h00};
   int          m_cnt      = 0;
   int          m_addr     = 0;
   logic [7:0]  m_cmd      = 8'h00;
   logic [63:0] m_frame    = 64'h0;
   logic [63:0] last_frame = 64'h0;
   int          last_rises = 0;

   always @(posedge spi_sclk or posedge spi_cs_n) begin
      if (spi_cs_n) begin
         if (m_cnt != 0) begin
            last_frame = m_frame;
            last_rises = m_cnt;
         end
         m_cnt   = 0;
         m_frame = 64'h0;
      end else begin
         m_frame = {m_frame[62:0], spi_mosi};
         m_cnt   = m_cnt + 1;
         if (m_cnt == 8)  m_cmd  = m_frame[7:0];
         if (m_cnt == 32) m_addr = int'(m_frame[23:0]);
         if (m_cnt > 32 && ((m_cnt - 32) % 8) == 0 && m_cmd == 8'h02)
            mem[(m_addr + (m_cnt - 40) / 8) & 1023] = m_frame[7:0];
      end
   end

   always @(negedge spi_sclk or negedge spi_cs_n) begin
      int idx;
      if (!spi_cs_n && m_cmd == 8'h03 && m_cnt >= 32 && m_cnt < 48) begin
         idx  = m_cnt - 32;
         miso = mem[(m_addr + idx / 8) & 1023][7 - (idx % 8)];
      end else begin
         miso = 1'b0;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks = checks + 1;
      if (act !== exp_v) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
      end
   endtask

   task automatic fail_bound(input string name);
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s: bound expired", name);
   endtask

   // called just after a negedge; returns the cycle stamp of the accept
   task automatic issue(input logic we, input logic [23:0] addr, input logic [15:0] wd,
                        input logic [63:0] frame, input logic [15:0] rdata,
                        input logic keep, output int t);
      exp_t e;
      int   n;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         fail_bound("accept");
         req_valid = 1'b0;
         t = -1;
         return;
      end
      t       = cyc;
      e.t_acc = cyc;
      e.frame = frame;
      e.rdata = rdata;
      exp_q.push_back(e);
      @(negedge clk);
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !req_ready) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) fail_bound("wait_done");
   endtask

   task automatic release_reset();
      int n;
      rstb = 1'b1;
`ifdef SPI_SRAM_INIT_EN
      n = 0;
      while (n < 400) begin
         @(negedge clk);
         n++;
         if (req_ready) break;
      end
      chk("init_ready_cycles", 64'(n), 64'd71);
      chk("init_rises", 64'(last_rises), 64'd16);
      chk("init_frame", last_frame, 64'h0140);
`else
      n = 0;
      @(negedge clk);
      chk("ready_after_release", 64'(req_ready), 64'd1);
`endif
   endtask

   // ---------------- response monitor ----------------
   initial begin
      exp_t e;
      int   hi_run;
      logic seen_low;
      hi_run   = 0;
      seen_low = 1'b0;
      forever begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               errors = errors + 1;
               checks = checks + 1;
               $display("FAIL unexpected_rsp: rsp_valid with no request outstanding, rdata=%0h", rsp_rdata);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_latency", 64'(cyc - e.t_acc), 64'd197);
               chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
               chk("frame_bits", last_frame, e.frame);
               chk("sclk_rises", 64'(last_rises), 64'd48);
            end
         end
         if (spi_cs_n === 1'b1) begin
            hi_run++;
         end else begin
            if (seen_low && hi_run > 0) chk("cs_high_ge2", 64'(hi_run >= 2), 64'd1);
            seen_low = 1'b1;
            hi_run   = 0;
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int t, t1, t2, t3, n;
      rstb      = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 24'h0;
      req_wdata = 16'h0;

      // reset state
      repeat (5) @(negedge clk);
      chk("rst_cs_n", 64'(spi_cs_n), 64'd1);
      chk("rst_sclk", 64'(spi_sclk), 64'd0);
      chk("rst_mosi", 64'(spi_mosi), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rdata", 64'(rsp_rdata), 64'd0);
      release_reset();

      // write 0x1234 @ 0x000100
      issue(1'b1, 24'h000100, 16'h1234, 64'h0000_0200_0100_1234, 16'h0000, 1'b0, t);
      wait_done();
      chk("mem_100", 64'(mem[256]), 64'h12);
      chk("mem_101", 64'(mem[257]), 64'h34);

      // read back 0x000100
      issue(1'b0, 24'h000100, 16'hFFFF, 64'h0000_0300_0100_0000, 16'h1234, 1'b0, t);
      wait_done();

      // req_valid held high across three requests
      issue(1'b1, 24'h000200, 16'hCAFE, 64'h0000_0200_0200_CAFE, 16'h1234, 1'b1, t1);
      issue(1'b0, 24'h000100, 16'h0000, 64'h0000_0300_0100_0000, 16'h1234, 1'b1, t2);
      issue(1'b0, 24'h000200, 16'h0000, 64'h0000_0300_0200_0000, 16'hCAFE, 1'b0, t3);
      chk("accept_spacing_1", 64'(t2 - t1), 64'd199);
      chk("accept_spacing_2", 64'(t3 - t2), 64'd199);
      wait_done();

      // reset pulse at the 20th SCLK rise of a write
      issue(1'b1, 24'h000300, 16'h1111, 64'h0000_0200_0300_1111, 16'hCAFE, 1'b0, t);
      n = 0;
      while (m_cnt < 20 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (m_cnt < 20) fail_bound("rise20");
      rstb = 1'b0;
      void'(exp_q.pop_back());
      @(negedge clk);
      chk("abort_cs_n", 64'(spi_cs_n), 64'd1);
      chk("abort_sclk", 64'(spi_sclk), 64'd0);
      chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("abort_ready", 64'(req_ready), 64'd0);
      chk("abort_rdata", 64'(rsp_rdata), 64'd0);
      release_reset();

      // write 0xBEEF @ 0x0001FE after the abort, then read it back
      issue(1'b1, 24'h0001FE, 16'hBEEF, 64'h0000_0200_01FE_BEEF, 16'h0000, 1'b0, t);
      wait_done();
      chk("mem_1fe", 64'(mem[510]), 64'hBE);
      chk("mem_1ff", 64'(mem[511]), 64'hEF);
      chk("mem_300_untouched", 64'(mem[768]), 64'h00);
      issue(1'b0, 24'h0001FE, 16'h0000, 64'h0000_0300_01FE_0000, 16'hBEEF, 1'b0, t);
      wait_done();

      repeat (20) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
